x_writeback_arbiter: RTL and testbench
======================================

# x_writeback_arbiter

Shares the single write port of the integer register file between several writeback sources (ALU, load/store unit, multiply/divide unit) using round-robin arbitration with a valid/ready handshake per source. It drives the register file's destination index and write data from registered outputs. It also keeps a busy scoreboard of destination registers with writes in flight, so the issue stage can stall on RAW/WAW hazards. It sits between the execution units and the register file write port.

## Interface
- NREQ, 3, number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = MDU
- iCLK  in  1  clock; all state updates on rising edge
- iRST  in  1  synchronous reset, active-high
- iREQ_VALID  in  NREQ  requester k has a pending write
- iREQ_RD  in  5*NREQ  destination index of requester k, bits [5k+4:5k]
- iREQ_DATA  in  32*NREQ  write data of requester k, bits [32k+31:32k]
- oREQ_READY  out  NREQ  one-hot grant; transfer occurs when valid & ready on a rising edge
- iISSUE_VALID  in  1  an instruction writing a register is issued this cycle
- iISSUE_RD  in  5  destination of the issued instruction
- oRD  out  5  register file write index; 0 means no write
- oWDATA  out  32  register file write data
- oBUSY  out  32  scoreboard; bit r set = write to xr outstanding; bit 0 always 0

## Operation
- Grant is combinational from iREQ_VALID and the round-robin pointer PTR (index of last granted requester). Search order is PTR+1, PTR+2, … modulo NREQ; the first valid requester gets oREQ_READY. At most one ready bit is set. No valid means all ready bits are 0.
- On a transfer (valid & ready for requester g), the edge loads oRD <= iREQ_RD[g], oWDATA <= iREQ_DATA[g] and PTR <= g.
- With no transfer, the edge loads oRD <= 0. oWDATA holds its value, and PTR holds.
- A requester with rd = 0 is still granted and consumed; oRD becomes 0, so no write occurs.
- Requester protocol:
  - valid must not depend on ready.
  - Once valid is asserted, rd and data stay stable and valid stays high until the transfer.
  - The arbiter never grants a requester whose valid is low.
- Scoreboard, evaluated on each edge:
  - clear bit oRD (the write being committed to the register file this cycle) when oRD != 0;
  - set bit iISSUE_RD when iISSUE_VALID and iISSUE_RD != 0;
  - when the same index is both set and cleared, set wins.
- The issue stage must not issue to an rd whose oBUSY bit is set (WAW). If it does anyway, the bit stays set and is cleared by the next commit to that rd.
- Reset: oRD = 0, oWDATA = 0, oBUSY = 0, PTR = NREQ-1 (so requester 0 wins first). oREQ_READY is forced to 0 while iRST is high. Reset during a pending request discards it; the requester keeps valid high and is re-arbitrated after reset.

## Timing
- Grant to register file write: a transfer at edge N presents oRD/oWDATA during cycle N+1. The register file captures at edge N+1.
- Throughput: one write per cycle. All NREQ requesters continuously valid are served in strict rotation, each once every NREQ cycles.
- Maximum wait for a continuously valid requester: NREQ-1 cycles.
- The oBUSY bit for rd clears at edge N+1, together with the register file update. An instruction reading rd may be issued from cycle N+2 without forwarding.
- An issue at edge M sets the bit, which is visible from cycle M+1.
- oREQ_READY has no register stage: valid to ready happens in the same cycle.

## Test plan
- Reset then single request: REQ1 valid, rd=5, data=0xDEADBEEF.
  - Required: READY=3'b010 the same cycle; next cycle oRD=5, oWDATA=0xDEADBEEF; the cycle after, oRD=0.
- All three valid continuously (rd=1, 2, 3) from reset.
  - Required: grant order 0, 1, 2, 0, 1, 2; oRD sequence 1, 2, 3, 1, …; no idle cycle.
- Requester 0 valid, then requester 2 also valid while 0 is still waiting (PTR=0).
  - Required: requester 0 is granted first, 2 next, and 0 is never granted twice in a row while 2 waits.
- Scoreboard: issue rd=7, then 2 cycles later REQ0 writes rd=7.
  - Required: oBUSY[7]=1 from the cycle after issue; clears at the edge where oRD=7 commits.
  - Simultaneous issue rd=7 with that commit: oBUSY[7] stays 1.
- x0 handling: issue rd=0 and REQ1 write rd=0.
  - Required: oBUSY stays 0, oRD stays 0, and the request is consumed (READY pulses for one cycle).
- Reset mid-stream with all requesters valid and oBUSY=0x00F0.
  - Required: during iRST, READY=0; after it, oRD=0 and oBUSY=0; the first grant goes to requester 0.

Source files
------------

// File: rtl/x_writeback_arbiter.sv
// Round-robin arbiter for the integer register file write port, with a busy
// scoreboard of destination registers whose writes are still in flight.
module x_writeback_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic [NREQ-1:0]     iREQ_VALID,
   input  logic [5*NREQ-1:0]   iREQ_RD,
   input  logic [32*NREQ-1:0]  iREQ_DATA,
   output logic [NREQ-1:0]     oREQ_READY,
   input  logic                iISSUE_VALID,
   input  logic [4:0]          iISSUE_RD,
   output logic [4:0]          oRD,
   output logic [31:0]         oWDATA,
   output logic [31:0]         oBUSY
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   ptr_q;
   logic [4:0]      rd_q;
   logic [31:0]     wdata_q;
   logic [31:0]     busy_q;
   logic [31:0]     busy_d;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [PW:0]     cand;
   logic [4:0]      sel_rd;
   logic [31:0]     sel_data;

   // Search starts just after the last winner and wraps modulo NREQ.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NREQ)) begin
            cand = cand - (PW+1)'(NREQ);
         end
         if (!grant_any && iREQ_VALID[cand[PW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PW-1:0];
         end
      end
      if (iRST) begin
         grant_any = 1'b0;
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (PW'(k) == grant_idx) begin
            sel_rd   = iREQ_RD[5*k +: 5];
            sel_data = iREQ_DATA[32*k +: 32];
         end
      end
   end

   // Commit clears first so a same-edge issue to the same rd leaves it set.
   always_comb begin
      busy_d = busy_q;
      if (rd_q != 5'd0) begin
         busy_d[rd_q] = 1'b0;
      end
      if (iISSUE_VALID && (iISSUE_RD != 5'd0)) begin
         busy_d[iISSUE_RD] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         ptr_q   <= PW'(NREQ - 1);
         rd_q    <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         if (grant_any) begin
            rd_q    <= sel_rd;
            wdata_q <= sel_data;
            ptr_q   <= grant_idx;
         end else begin
            rd_q <= '0;
         end
         busy_q <= busy_d;
      end
   end

   assign oREQ_READY = grant;
   assign oRD        = rd_q;
   assign oWDATA     = wdata_q;
   assign oBUSY      = busy_q;

endmodule

// File: tb/tb_x_writeback_arbiter.sv
// Directed bench for x_writeback_arbiter: grant order, commit timing,
// scoreboard set/clear behaviour, x0 handling and mid-stream reset.
module tb_x_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rd;
   logic [31:0] wdata;
   logic [31:0] busy;

   int pass_cnt = 0;
   int fail_cnt = 0;
   int total    = 0;

   x_writeback_arbiter #(.NREQ(3)) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iREQ_VALID   (req_valid),
      .iREQ_RD      (req_rd),
      .iREQ_DATA    (req_data),
      .oREQ_READY   (req_ready),
      .iISSUE_VALID (issue_valid),
      .iISSUE_RD    (issue_rd),
      .oRD          (rd),
      .oWDATA       (wdata),
      .oBUSY        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the end of the sequence");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int g;
      rst         = 1'b1;
      req_valid   = 3'b111;
      req_rd      = {5'd3, 5'd2, 5'd1};
      req_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      step();
      step();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_wdata", wdata, 32'h0);
      chk("rst_busy", busy, 32'h0);

      // Single request from requester 1
      rst       = 1'b0;
      req_valid = 3'b010;
      req_rd    = {5'd0, 5'd5, 5'd0};
      req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
      #1;
      chk("single_ready", 32'(req_ready), 32'h2);
      step();
      chk("single_rd", 32'(rd), 32'd5);
      chk("single_wdata", wdata, 32'hDEADBEEF);
      req_valid = 3'b000;
      #1;
      chk("single_idle_ready", 32'(req_ready), 32'h0);
      step();
      chk("single_rd_idle", 32'(rd), 32'd0);
      chk("single_wdata_hold", wdata, 32'hDEADBEEF);

      // All valid from reset: strict rotation 0,1,2,0,1,2
      rst       = 1'b1;
      req_valid = 3'b111;
      req_rd    = {5'd3, 5'd2, 5'd1};
      req_data  = {32'h300, 32'h200, 32'h100};
      #1;
      chk("rot_rst_ready", 32'(req_ready), 32'h0);
      step();
      rst = 1'b0;
      #1;
      for (int n = 0; n < 6; n++) begin
         g = n % 3;
         chk("rot_ready", 32'(req_ready), 32'(1 << g));
         step();
         chk("rot_rd", 32'(rd), 32'(g + 1));
         chk("rot_wdata", wdata, 32'((g + 1) * 256));
      end
      req_valid = 3'b000;
      step();
      chk("rot_rd_idle", 32'(rd), 32'd0);

      // Fairness with PTR=0: 0 granted, then 2, then 0 again
      req_rd    = {5'd6, 5'd0, 5'd4};
      req_valid = 3'b001;
      #1;
      chk("fair_ready0", 32'(req_ready), 32'h1);
      step();
      chk("fair_rd0", 32'(rd), 32'd4);
      req_valid = 3'b101;
      #1;
      chk("fair_ready2", 32'(req_ready), 32'h4);
      step();
      chk("fair_rd2", 32'(rd), 32'd6);
      req_valid = 3'b001;
      #1;
      chk("fair_ready0b", 32'(req_ready), 32'h1);
      step();
      chk("fair_rd0b", 32'(rd), 32'd4);
      req_valid = 3'b000;
      step();

      // Scoreboard: issue rd=7, commit two cycles later
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      step();
      issue_valid = 1'b0;
      chk("sb_set", busy, 32'h80);
      step();
      chk("sb_hold", busy, 32'h80);
      req_rd    = {5'd0, 5'd0, 5'd7};
      req_valid = 3'b001;
      #1;
      chk("sb_ready", 32'(req_ready), 32'h1);
      step();
      chk("sb_commit_rd", 32'(rd), 32'd7);
      chk("sb_busy_at_commit", busy, 32'h80);
      req_valid = 3'b000;
      step();
      chk("sb_cleared", busy, 32'h0);
      chk("sb_rd_idle", 32'(rd), 32'd0);

      // Issue to rd=7 on the same edge its commit clears: set wins
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      step();
      issue_valid = 1'b0;
      req_valid   = 3'b001;
      step();
      chk("sbw_rd", 32'(rd), 32'd7);
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      req_valid   = 3'b000;
      step();
      issue_valid = 1'b0;
      chk("sbw_set_wins", busy, 32'h80);
      req_valid = 3'b001;
      step();
      req_valid = 3'b000;
      step();
      chk("sbw_cleared", busy, 32'h0);

      // x0: issue to x0, requester 1 writes x0
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      req_valid   = 3'b010;
      req_rd      = '0;
      req_data    = {32'h0, 32'h12345678, 32'h0};
      #1;
      chk("x0_ready", 32'(req_ready), 32'h2);
      step();
      issue_valid = 1'b0;
      req_valid   = 3'b000;
      chk("x0_rd", 32'(rd), 32'd0);
      chk("x0_busy", busy, 32'h0);
      chk("x0_wdata", wdata, 32'h12345678);

      // Mid-stream reset with busy = 0x00F0
      for (int r = 4; r < 8; r++) begin
         issue_valid = 1'b1;
         issue_rd    = 5'(r);
         step();
      end
      issue_valid = 1'b0;
      chk("mrst_busy_pre", busy, 32'hF0);
      req_valid = 3'b111;
      req_rd    = {5'd3, 5'd2, 5'd1};
      req_data  = {32'h300, 32'h200, 32'h100};
      #1;
      chk("mrst_ready_pre", 32'(req_ready), 32'h4);
      step();
      chk("mrst_rd_pre", 32'(rd), 32'd3);
      rst = 1'b1;
      #1;
      chk("mrst_ready_in_rst", 32'(req_ready), 32'h0);
      step();
      chk("mrst_rd", 32'(rd), 32'd0);
      chk("mrst_busy", busy, 32'h0);
      rst = 1'b0;
      #1;
      chk("mrst_first_grant", 32'(req_ready), 32'h1);
      step();
      chk("mrst_first_rd", 32'(rd), 32'd1);
      req_valid = 3'b000;

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
